// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: states, opcodes, AluOp and mux selects.
// The TRAP state exists only when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
package multicycle_main_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ,ST_TRAP    = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_OP_ADD   = 3'd0;
    localparam logic [2:0] ALU_OP_SUB   = 3'd1;
    localparam logic [2:0] ALU_OP_AND   = 3'd2;
    localparam logic [2:0] ALU_OP_OR    = 3'd3;
    localparam logic [2:0] ALU_OP_FUNCT = 3'd4;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_B_REGB    = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    // Bundle of every strobe the control drives; all-zero is the idle/no-write word.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Immediate-ALU instructions pick their AluOp straight from the opcode.
    function automatic logic [2:0] alu_op_for_imm(input logic [5:0] op);
        logic [2:0] r_op;
        case (op)
            OP_ANDI: r_op = ALU_OP_AND;
            OP_ORI:  r_op = ALU_OP_OR;
            default: r_op = ALU_OP_ADD;
        endcase
        return r_op;
    endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Next-state function of the multi-cycle main control; purely combinational.
// Undefined opcodes go to TRAP when MULTICYCLE_ILLEGAL_TRAP_EN is defined, else back to FETCH.
module multicycle_next_state
    import multicycle_main_control_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_opcode,
    input  logic        i_mem_ready,
    output state_t      o_state_next
);

    always_comb begin
        o_state_next = i_state;
        case (i_state)
            ST_FETCH: begin
                if (i_mem_ready) begin
                    o_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:        o_state_next = ST_EXEC_R;
                    OP_LW, OP_SW:    o_state_next = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:  o_state_next = ST_BRANCH;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:          o_state_next = ST_EXEC_I;
                    OP_J:            o_state_next = ST_JUMP;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:         o_state_next = ST_TRAP;
`else
                    default:         o_state_next = ST_FETCH;
`endif
                endcase
            end
            ST_MEM_ADDR: begin
                o_state_next = (i_opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (i_mem_ready) begin
                    o_state_next = ST_MEM_WB;
                end
            end
            ST_MEM_WB:  o_state_next = ST_FETCH;
            ST_MEM_WR: begin
                if (i_mem_ready) begin
                    o_state_next = ST_FETCH;
                end
            end
            ST_EXEC_R:  o_state_next = ST_WB_R;
            ST_WB_R:    o_state_next = ST_FETCH;
            ST_EXEC_I:  o_state_next = ST_WB_I;
            ST_WB_I:    o_state_next = ST_FETCH;
            ST_BRANCH:  o_state_next = ST_FETCH;
            ST_JUMP:    o_state_next = ST_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            ST_TRAP:    o_state_next = ST_TRAP;
`endif
            default:    o_state_next = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS main control: state register plus Moore output decode (FETCH and BRANCH
// write enables also look at mem_ready / zero). MULTICYCLE_ILLEGAL_TRAP_EN enables the sticky TRAP.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [3:0]  state,
    output logic        illegal
);

    state_t r_state;
    state_t w_state_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    multicycle_next_state u_next_state (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_mem_ready  (mem_ready),
        .o_state_next (w_state_next)
    );

    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.alu_src_b = ALU_B_FOUR;
                w_ctrl.alu_op    = ALU_OP_ADD;
                w_ctrl.pc_src    = PC_SRC_ALU;
                w_ctrl.ir_we     = mem_ready;
                w_ctrl.pc_we     = mem_ready;
            end
            ST_DECODE: begin
                w_ctrl.alu_src_b = ALU_B_IMM_SH2;
                w_ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALU_B_IMM;
                w_ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                w_ctrl.reg_we     = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
                w_ctrl.mem_we  = 1'b1;
            end
            ST_EXEC_R: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALU_B_REGB;
                w_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_WB_R: begin
                w_ctrl.reg_we  = 1'b1;
                w_ctrl.reg_dst = 1'b1;
            end
            ST_EXEC_I: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALU_B_IMM;
                w_ctrl.alu_op    = alu_op_for_imm(opcode);
            end
            ST_WB_I: begin
                w_ctrl.reg_we = 1'b1;
            end
            ST_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = ALU_B_REGB;
                w_ctrl.alu_op    = ALU_OP_SUB;
                w_ctrl.pc_src    = PC_SRC_ALUOUT;
                w_ctrl.pc_we     = (opcode == OP_BNE) ? ~zero : zero;
            end
            ST_JUMP: begin
                w_ctrl.pc_src = PC_SRC_JUMP;
                w_ctrl.pc_we  = 1'b1;
            end
            default: begin
                w_ctrl = CTRL_IDLE;
            end
        endcase
    end

    // Reset kills every strobe combinationally so an in-flight request drops in the same cycle.
    assign w_ctrl_out = rst ? CTRL_IDLE : w_ctrl;

    assign mem_req    = w_ctrl_out.mem_req;
    assign mem_we     = w_ctrl_out.mem_we;
    assign iord       = w_ctrl_out.iord;
    assign ir_we      = w_ctrl_out.ir_we;
    assign pc_we      = w_ctrl_out.pc_we;
    assign pc_src     = w_ctrl_out.pc_src;
    assign alu_src_a  = w_ctrl_out.alu_src_a;
    assign alu_src_b  = w_ctrl_out.alu_src_b;
    assign alu_op     = w_ctrl_out.alu_op;
    assign reg_we     = w_ctrl_out.reg_we;
    assign reg_dst    = w_ctrl_out.reg_dst;
    assign mem_to_reg = w_ctrl_out.mem_to_reg;
    assign state      = r_state;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign illegal = ~rst & (r_state == ST_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed table-driven bench for multicycle_main_control, plus hand sequences for the
// illegal-opcode path (with or without MULTICYCLE_ILLEGAL_TRAP_EN) and reset during MEM_WR.
module tb_multicycle_main_control;
    import multicycle_main_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_we, reg_dst, mem_to_reg;
    logic [3:0]  state;
    logic        illegal;

    multicycle_main_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] act_ctrl;
    assign act_ctrl = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                       alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg};

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        string       tag;
    } vec_t;

    vec_t rows[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_FUNCT = 3'd4;

    function automatic logic [15:0] ctl(input logic mreq, input logic mwe, input logic io,
                                        input logic irw, input logic pcw, input logic [1:0] pcs,
                                        input logic a, input logic [1:0] b, input logic [2:0] op,
                                        input logic rw, input logic rd, input logic m2r);
        return {mreq, mwe, io, irw, pcw, pcs, a, b, op, rw, rd, m2r};
    endfunction

    // Hand-written expected control words per state/condition.
    logic [15:0] E_FETCH_GO, E_FETCH_WAIT, E_DECODE, E_EXEC_R, E_WB_R, E_MEM_ADDR, E_MEM_RD;
    logic [15:0] E_MEM_WB, E_MEM_WR, E_EXEC_ORI, E_EXEC_ANDI, E_EXEC_ADDI, E_WB_I;
    logic [15:0] E_BR_TAKEN, E_BR_NOT, E_JUMP;

    task automatic add(input logic [5:0] op, input logic z, input logic rdy,
                       input state_t st, input logic [15:0] c, input string tag);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = c; v.tag = tag;
        rows.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", name, got, exp);
        end
    endtask

    initial begin
        E_FETCH_GO   = ctl(1,0,0,1,1,2'b00,0,2'b01,A_ADD,0,0,0);
        E_FETCH_WAIT = ctl(1,0,0,0,0,2'b00,0,2'b01,A_ADD,0,0,0);
        E_DECODE     = ctl(0,0,0,0,0,2'b00,0,2'b11,A_ADD,0,0,0);
        E_EXEC_R     = ctl(0,0,0,0,0,2'b00,1,2'b00,A_FUNCT,0,0,0);
        E_WB_R       = ctl(0,0,0,0,0,2'b00,0,2'b00,A_ADD,1,1,0);
        E_MEM_ADDR   = ctl(0,0,0,0,0,2'b00,1,2'b10,A_ADD,0,0,0);
        E_MEM_RD     = ctl(1,0,1,0,0,2'b00,0,2'b00,A_ADD,0,0,0);
        E_MEM_WB     = ctl(0,0,0,0,0,2'b00,0,2'b00,A_ADD,1,0,1);
        E_MEM_WR     = ctl(1,1,1,0,0,2'b00,0,2'b00,A_ADD,0,0,0);
        E_EXEC_ORI   = ctl(0,0,0,0,0,2'b00,1,2'b10,A_OR,0,0,0);
        E_EXEC_ANDI  = ctl(0,0,0,0,0,2'b00,1,2'b10,A_AND,0,0,0);
        E_EXEC_ADDI  = ctl(0,0,0,0,0,2'b00,1,2'b10,A_ADD,0,0,0);
        E_WB_I       = ctl(0,0,0,0,0,2'b00,0,2'b00,A_ADD,1,0,0);
        E_BR_TAKEN   = ctl(0,0,0,0,1,2'b01,1,2'b00,A_SUB,0,0,0);
        E_BR_NOT     = ctl(0,0,0,0,0,2'b01,1,2'b00,A_SUB,0,0,0);
        E_JUMP       = ctl(0,0,0,0,1,2'b10,0,2'b00,A_ADD,0,0,0);

        // R-type, 4 cycles; mem_ready pulses in DECODE/EXEC_R must be ignored
        add(6'b000000, 0, 1, ST_FETCH,    E_FETCH_GO,  "r_fetch");
        add(6'b000000, 0, 1, ST_DECODE,   E_DECODE,    "r_decode");
        add(6'b000000, 1, 1, ST_EXEC_R,   E_EXEC_R,    "r_exec");
        add(6'b000000, 0, 0, ST_WB_R,     E_WB_R,      "r_wb");
        // LW with 3 wait states, 8 cycles
        add(6'b100011, 0, 1, ST_FETCH,    E_FETCH_GO,  "lw_fetch");
        add(6'b100011, 0, 0, ST_DECODE,   E_DECODE,    "lw_decode");
        add(6'b100011, 0, 0, ST_MEM_ADDR, E_MEM_ADDR,  "lw_addr");
        add(6'b100011, 0, 0, ST_MEM_RD,   E_MEM_RD,    "lw_wait1");
        add(6'b100011, 1, 0, ST_MEM_RD,   E_MEM_RD,    "lw_wait2");
        add(6'b100011, 0, 0, ST_MEM_RD,   E_MEM_RD,    "lw_wait3");
        add(6'b100011, 0, 1, ST_MEM_RD,   E_MEM_RD,    "lw_ready");
        add(6'b100011, 0, 0, ST_MEM_WB,   E_MEM_WB,    "lw_wb");
        // BEQ taken, with one fetch wait cycle
        add(6'b000100, 0, 0, ST_FETCH,    E_FETCH_WAIT,"beq_fwait");
        add(6'b000100, 0, 1, ST_FETCH,    E_FETCH_GO,  "beq_fetch");
        add(6'b000100, 0, 0, ST_DECODE,   E_DECODE,    "beq_decode");
        add(6'b000100, 1, 0, ST_BRANCH,   E_BR_TAKEN,  "beq_z1");
        // BNE with zero=1 (not taken) and zero=0 (taken)
        add(6'b000101, 0, 1, ST_FETCH,    E_FETCH_GO,  "bne_fetch");
        add(6'b000101, 0, 0, ST_DECODE,   E_DECODE,    "bne_decode");
        add(6'b000101, 1, 0, ST_BRANCH,   E_BR_NOT,    "bne_z1");
        add(6'b000101, 0, 1, ST_FETCH,    E_FETCH_GO,  "bne2_fetch");
        add(6'b000101, 0, 0, ST_DECODE,   E_DECODE,    "bne2_decode");
        add(6'b000101, 0, 0, ST_BRANCH,   E_BR_TAKEN,  "bne_z0");
        // ORI / ANDI / ADDI
        add(6'b001101, 0, 1, ST_FETCH,    E_FETCH_GO,  "ori_fetch");
        add(6'b001101, 0, 0, ST_DECODE,   E_DECODE,    "ori_decode");
        add(6'b001101, 0, 0, ST_EXEC_I,   E_EXEC_ORI,  "ori_exec");
        add(6'b001101, 0, 0, ST_WB_I,     E_WB_I,      "ori_wb");
        add(6'b001100, 0, 1, ST_FETCH,    E_FETCH_GO,  "andi_fetch");
        add(6'b001100, 0, 0, ST_DECODE,   E_DECODE,    "andi_decode");
        add(6'b001100, 0, 0, ST_EXEC_I,   E_EXEC_ANDI, "andi_exec");
        add(6'b001100, 0, 0, ST_WB_I,     E_WB_I,      "andi_wb");
        add(6'b001000, 0, 1, ST_FETCH,    E_FETCH_GO,  "addi_fetch");
        add(6'b001000, 0, 0, ST_DECODE,   E_DECODE,    "addi_decode");
        add(6'b001000, 0, 0, ST_EXEC_I,   E_EXEC_ADDI, "addi_exec");
        add(6'b001000, 0, 0, ST_WB_I,     E_WB_I,      "addi_wb");
        // SW with one wait state
        add(6'b101011, 0, 1, ST_FETCH,    E_FETCH_GO,  "sw_fetch");
        add(6'b101011, 0, 0, ST_DECODE,   E_DECODE,    "sw_decode");
        add(6'b101011, 0, 0, ST_MEM_ADDR, E_MEM_ADDR,  "sw_addr");
        add(6'b101011, 0, 0, ST_MEM_WR,   E_MEM_WR,    "sw_wait");
        add(6'b101011, 0, 1, ST_MEM_WR,   E_MEM_WR,    "sw_ready");
        // J, 3 cycles
        add(6'b000010, 0, 1, ST_FETCH,    E_FETCH_GO,  "j_fetch");
        add(6'b000010, 0, 0, ST_DECODE,   E_DECODE,    "j_decode");
        add(6'b000010, 0, 0, ST_JUMP,     E_JUMP,      "j_jump");
        add(6'b000000, 0, 0, ST_FETCH,    E_FETCH_WAIT,"idle_fetch");

        // Reset state
        rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_state", {12'd0, state}, {12'd0, ST_FETCH});
        check("reset_ctl", act_ctrl, 16'h0000);
        check("reset_illegal", {15'd0, illegal}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < rows.size(); i++) begin
            opcode = rows[i].op; zero = rows[i].z; mem_ready = rows[i].rdy;
            #1;
            check({rows[i].tag, "_state"}, {12'd0, state}, {12'd0, rows[i].st});
            check({rows[i].tag, "_ctl"}, act_ctrl, rows[i].ctl);
            $display("cycle %0d %s op=%b z=%0d rdy=%0d state=%0d ctl=%04h",
                     i, rows[i].tag, rows[i].op, rows[i].z, rows[i].rdy, state, act_ctrl);
            @(negedge clk);
        end

        // Undefined opcode 6'b111111
        opcode = 6'b111111; zero = 1'b0; mem_ready = 1'b1;
        #1;
        check("ill_fetch_state", {12'd0, state}, {12'd0, ST_FETCH});
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("ill_decode_state", {12'd0, state}, {12'd0, ST_DECODE});
        check("ill_decode_ctl", act_ctrl, E_DECODE);
        @(negedge clk);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        mem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("trap_state", {12'd0, state}, {12'd0, ST_TRAP});
            check("trap_ctl", act_ctrl, 16'h0000);
            check("trap_illegal", {15'd0, illegal}, 16'd1);
            $display("trap cycle %0d state=%0d illegal=%0d", c, state, illegal);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("trap_rst_state", {12'd0, state}, {12'd0, ST_FETCH});
        check("trap_rst_illegal", {15'd0, illegal}, 16'd0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("trap_after_rst_ctl", act_ctrl, E_FETCH_WAIT);
`else
        #1;
        check("ill_nop_state", {12'd0, state}, {12'd0, ST_FETCH});
        check("ill_nop_ctl", act_ctrl, E_FETCH_WAIT);
        check("ill_nop_illegal", {15'd0, illegal}, 16'd0);
        $display("illegal opcode returned to state=%0d", state);
`endif
        @(negedge clk);

        // Reset asserted while MEM_WR holds a request
        opcode = 6'b101011; zero = 1'b0; mem_ready = 1'b1;
        #1;
        check("rsw_fetch_state", {12'd0, state}, {12'd0, ST_FETCH});
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rsw_addr_state", {12'd0, state}, {12'd0, ST_MEM_ADDR});
        @(negedge clk);
        #1;
        check("rsw_wr_state", {12'd0, state}, {12'd0, ST_MEM_WR});
        check("rsw_wr_ctl", act_ctrl, E_MEM_WR);
        #1;
        rst = 1'b1;
        #1;
        check("rsw_rst_mem_req", {15'd0, mem_req}, 16'd0);
        check("rsw_rst_ctl", act_ctrl, 16'h0000);
        check("rsw_rst_state", {12'd0, state}, {12'd0, ST_FETCH});
        @(negedge clk);
        #1;
        check("rsw_rst_hold_ctl", act_ctrl, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rsw_rel_state", {12'd0, state}, {12'd0, ST_FETCH});
        check("rsw_rel_mem_req", {15'd0, mem_req}, 16'd1);
        check("rsw_rel_ctl", act_ctrl, E_FETCH_WAIT);
        $display("reset during MEM_WR: state=%0d mem_req=%0d", state, mem_req);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle MIPS main control FSM. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces the 3-bit AluOp code consumed by the ALU control decoder, plus all datapath and memory-handshake strobes.
- Sits between the instruction register's opcode field and the datapath muxes and write enables.

Parameters:
- none (all encodings come from the shared package)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26], stable after fetch
- zero  input  1  ALU zero flag, same cycle
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request
- mem_we  output  1  1=write, 0=read; valid while mem_req
- iord  output  1  address select: 0=PC, 1=ALUOut
- ir_we  output  1  instruction register load
- pc_we  output  1  PC load (final; includes branch condition)
- pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_src_a  output  1  0=PC, 1=regA
- alu_src_b  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  output  3  AluOp: ADD, SUB, AND, OR, FUNCT
- reg_we  output  1  register file write
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=MDR
- state  output  4  current state, for debug
- illegal  output  1  sticky trap flag; only with the feature enabled, otherwise tied 0

Behaviour:
- Reset is asynchronous and active-high. It forces state=FETCH. While rst=1, every output including mem_req is 0 and state reads FETCH.
- Reset mid-operation aborts any in-flight memory request immediately. No partial writes are issued.
- Outputs are Moore-decoded from state. Exceptions: pc_we/ir_we in FETCH depend on mem_ready, and pc_we in BRANCH depends on zero. Any control not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. If mem_ready: ir_we=1, pc_we=1, go to DECODE. Otherwise hold with no writes.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 001000, 001100 or 001101 -> EXEC_I
  - 000010 -> JUMP
  - anything else -> ILLEGAL handling (see Optional Feature)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, iord=1, mem_we=0. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEM_WR: mem_req=1, iord=1, mem_we=1. Wait for mem_ready, then go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNCT. Go to WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_op is ADD for ADDI, AND for ANDI, OR for ORI. Go to WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01. pc_we=zero for BEQ, pc_we=~zero for BNE. Go to FETCH.
- JUMP: pc_src=10, pc_we=1. Go to FETCH.
- Handshake rules:
  - mem_req, iord and mem_we stay stable until the cycle mem_ready is sampled high.
  - mem_ready is ignored while mem_req=0.
  - Exactly one transfer per request. No back-to-back request without a state change.
- Cycle counts with zero wait states: R/I-type 4, LW 5, SW 4, branch 3, J 3. Each memory wait cycle adds 1.
- The state register updates only on clk rising edge or rst.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in DECODE goes to TRAP.
  - TRAP drives all enables 0 and mem_req=0, holds illegal=1, and stays until rst.
- Undefined:
  - An undefined opcode in DECODE returns to FETCH as a 2-cycle NOP with no writes.
  - illegal is tied 0 and no TRAP state exists.

Decomposition:
- Shared package holds:
  - the state enum (4-bit)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J)
  - AluOp constants (ALU_OP_ADD=0, SUB=1, AND=2, OR=3, FUNCT=4)
  - pc_src and alu_src_b encodings
- One sub-module: multicycle_next_state, a pure combinational function of (state, opcode, mem_ready). The top module keeps the state register and output decode.

Test Plan:
- Reset held mid-MEM_WR with mem_req=1 -> mem_req=0 in the same cycle; after release, state=FETCH and mem_req=1 on the next cycle.
- R-type (opcode 0) with mem_ready=1 in fetch -> DECODE, then EXEC_R with alu_op=FUNCT, then WB_R with reg_we=1, reg_dst=1, back to FETCH; 4 cycles total.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_req and iord held at 1 and no reg_we during the wait; MEM_WB on the cycle after ready, with mem_to_reg=1; 8 cycles total.
- BEQ with zero=1 -> pc_we=1, pc_src=01. BNE with zero=1 -> pc_we=0. ORI -> alu_op=OR in EXEC_I.
- Opcode 6'b111111 -> without the macro, FETCH after DECODE with no writes; with MULTICYCLE_ILLEGAL_TRAP_EN, illegal=1 and TRAP held for 10 cycles until rst.
- mem_ready pulsed while in DECODE or EXEC_R -> no effect on state or any enable.
